framebuffer_scanout: RTL
========================

// Module: framebuffer_scanout
// PURPOSE
//  Read side of the framebuffer dpram: walks the 320x240 RGB565 framebuffer in raster order
//  and emits a 640x480@60 VGA-style stream (2x pixel/line replication) with hsync/vsync/de.
//  Runs entirely in the display clock domain and drives the dpram rd_addr/rd_out port pair.
//  Replaces the external x_in/y_in coordinate source at the display end of the framebuffer.
// PARAMETERS
//  DISPLAY_WIDTH   320  source framebuffer width (pixels)
//  DISPLAY_HEIGHT  240  source framebuffer height (lines)
//  SCALE           2    replication factor, horizontal and vertical
//  H_FP/H_SYNC/H_BP 16/96/48   horizontal porch/sync widths (display clocks)
//  V_FP/V_SYNC/V_BP 10/2/33    vertical porch/sync widths (display lines)
//  RD_LATENCY      1    dpram read latency (cycles from rd_addr to valid rd_out)
//  SYNC_ACTIVE     0    asserted level of hsync/vsync
// PORTS
//  display_out_clk in  1   display clock; all logic on rising edge
//  rst             in  1   synchronous, active-high reset
//  fb_rd_addr      out 17  framebuffer read address ($clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT))
//  fb_rd_data      in  16  framebuffer read data, valid RD_LATENCY cycles after fb_rd_addr
//  pixel_out       out 16  RGB565 pixel; 0 whenever de=0
//  hsync           out 1   horizontal sync, level SYNC_ACTIVE when asserted
//  vsync           out 1   vertical sync, level SYNC_ACTIVE when asserted
//  de              out 1   data enable, 1 during 640x480 active area
//  frame_start     out 1   one-cycle pulse coincident with first active pixel of a frame
// BEHAVIOUR
//  - Clock and reset: one clock (display_out_clk); reset is synchronous and active-high (rst).
//  - Reset: h_cnt=v_cnt=0, line_base=0, src_x=0, fb_rd_addr=0, pixel_out=0, de=0,
//    frame_start=0, hsync=vsync=!SYNC_ACTIVE, all pipeline stages cleared. rst mid-frame
//    aborts the frame; first cycle after rst falls restarts at h=0,v=0.
//  - H_ACT=DISPLAY_WIDTH*SCALE, H_TOT=H_ACT+H_FP+H_SYNC+H_BP (800); V likewise (480/525).
//  - h_cnt counts 0..H_TOT-1 and wraps to 0; on wrap v_cnt increments, wraps at V_TOT-1.
//  - Active: h_cnt<H_ACT && v_cnt<V_ACT. hsync asserted for h in [H_ACT+H_FP, +H_SYNC);
//    vsync asserted for v in [V_ACT+V_FP, +V_SYNC), whole lines.
//  - Addressing, no multiplier: src_x advances every SCALE active clocks, resets at h wrap;
//    line_base += DISPLAY_WIDTH at h wrap when (v_cnt%SCALE)==SCALE-1 and v_cnt<V_ACT;
//    line_base=0 at v wrap. fb_rd_addr <= line_base+src_x when active, else 0 (registered).
//  - Pipeline: total latency L=RD_LATENCY+2 from counter state to outputs (1 addr reg,
//    RD_LATENCY RAM, 1 output reg). de/hsync/vsync/frame_start delayed by an L-deep shift
//    register so all outputs are mutually aligned. pixel_out <= de_pipe ? fb_rd_data : 0.
//  - Max address 76799; never exceeds DISPLAY_WIDTH*DISPLAY_HEIGHT-1.
// STRUCTURE
//  - gfx_pkg: pixel_t (16-bit RGB565), VGA 640x480 timing localparams, addr width function.
//  - Sub-module vga_timing_gen: h/v counters, active/hsync/vsync/frame-start generation.
//    framebuffer_scanout adds address generation, sync delay line and output register.
// TESTING
//  1 Release rst, RD_LATENCY=1 -> de first rises at cycle 3; fb_rd_addr sequence
//    0,0,1,1,2,2,... over first line; frame_start high for exactly that one cycle.
//  2 Line timing -> de high 640 cycles, period 800; hsync low (SYNC_ACTIVE=0) 96 cycles
//    beginning 16 cycles after de falls.
//  3 Line doubling -> display lines 0,1 read base 0; lines 2,3 base 320; line 479 base
//    76480; last address issued per frame 76799, then 0.
//  4 Frame timing -> frame_start period 420000 cycles; vsync low for lines 490-491 only.
//  5 fb_rd_data model returns 16'hFFFF for every address -> pixel_out=0 whenever de=0.
//  6 rst pulsed 1 cycle mid-line 100 -> next cycle all outputs at reset values;
//    frame_start recurs 3 cycles after rst falls.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics types and default 320x240 -> 640x480@60 scan-out timing.
package gfx_pkg;

  localparam int unsigned FB_WIDTH      = 320;
  localparam int unsigned FB_HEIGHT     = 240;
  localparam int unsigned FB_SCALE      = 2;
  localparam int unsigned FB_RD_LATENCY = 1;

  localparam int unsigned VGA_H_ACT  = FB_WIDTH * FB_SCALE;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_V_ACT  = FB_HEIGHT * FB_SCALE;
  localparam int unsigned VGA_V_FP   = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 33;

  localparam int unsigned PIX_W = 16;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } pixel_t;

  // Width of a counter holding 0..n-1 (never below one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Framebuffer read-address width for a w x h surface.
  function automatic int unsigned addr_width(input int unsigned w, input int unsigned h);
    return cnt_width(w * h);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster h/v counters with combinational active, sync and frame-start decodes.
module vga_timing_gen
  import gfx_pkg::*;
#(
  parameter int unsigned H_ACT  = VGA_H_ACT,
  parameter int unsigned H_FP   = VGA_H_FP,
  parameter int unsigned H_SYNC = VGA_H_SYNC,
  parameter int unsigned H_BP   = VGA_H_BP,
  parameter int unsigned V_ACT  = VGA_V_ACT,
  parameter int unsigned V_FP   = VGA_V_FP,
  parameter int unsigned V_SYNC = VGA_V_SYNC,
  parameter int unsigned V_BP   = VGA_V_BP
) (
  input  logic clk,
  input  logic rst,
  output logic h_wrap_c,
  output logic v_wrap_c,
  output logic v_active_c,
  output logic active_c,
  output logic hsync_c,
  output logic vsync_c,
  output logic frame_start_c
);

  localparam int unsigned H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W    = cnt_width(H_TOT);
  localparam int unsigned V_W    = cnt_width(V_TOT);
  localparam int unsigned HS_BEG = H_ACT + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACT + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           v_last;

  assign v_last   = (v_cnt == V_W'(V_TOT - 1));
  assign h_wrap_c = (h_cnt == H_W'(H_TOT - 1));
  assign v_wrap_c = h_wrap_c && v_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap_c) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

  // Decodes are taken straight from the counter state; the caller aligns them.
  assign v_active_c    = (v_cnt < V_W'(V_ACT));
  assign active_c      = (h_cnt < H_W'(H_ACT)) && v_active_c;
  assign hsync_c       = (h_cnt >= H_W'(HS_BEG)) && (h_cnt < H_W'(HS_END));
  assign vsync_c       = (v_cnt >= V_W'(VS_BEG)) && (v_cnt < V_W'(VS_END));
  assign frame_start_c = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer read side: raster address generation with pixel/line replication,
// sync delay line matched to the dpram latency, and registered video outputs.
module framebuffer_scanout
  import gfx_pkg::*;
#(
  parameter int unsigned DISPLAY_WIDTH  = FB_WIDTH,
  parameter int unsigned DISPLAY_HEIGHT = FB_HEIGHT,
  parameter int unsigned SCALE          = FB_SCALE,
  parameter int unsigned H_FP           = VGA_H_FP,
  parameter int unsigned H_SYNC         = VGA_H_SYNC,
  parameter int unsigned H_BP           = VGA_H_BP,
  parameter int unsigned V_FP           = VGA_V_FP,
  parameter int unsigned V_SYNC         = VGA_V_SYNC,
  parameter int unsigned V_BP           = VGA_V_BP,
  parameter int unsigned RD_LATENCY     = FB_RD_LATENCY,
  parameter bit          SYNC_ACTIVE    = 1'b0,
  parameter int unsigned ADDR_W         = addr_width(DISPLAY_WIDTH, DISPLAY_HEIGHT)
) (
  input  logic              display_out_clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [PIX_W-1:0]  fb_rd_data,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  localparam int unsigned H_ACT = DISPLAY_WIDTH * SCALE;
  localparam int unsigned V_ACT = DISPLAY_HEIGHT * SCALE;
  localparam int unsigned X_W   = cnt_width(DISPLAY_WIDTH + 1);
  localparam int unsigned SUB_W = cnt_width(SCALE);
  // Stages between the counters and the output register: address reg + RAM.
  localparam int unsigned PIPE  = RD_LATENCY + 1;

  logic h_wrap_c, v_wrap_c, v_active_c, active_c, hsync_c, vsync_c, frame_start_c;

  vga_timing_gen #(
    .H_ACT  (H_ACT),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_ACT  (V_ACT),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clk           (display_out_clk),
    .rst           (rst),
    .h_wrap_c      (h_wrap_c),
    .v_wrap_c      (v_wrap_c),
    .v_active_c    (v_active_c),
    .active_c      (active_c),
    .hsync_c       (hsync_c),
    .vsync_c       (vsync_c),
    .frame_start_c (frame_start_c)
  );

  logic [ADDR_W-1:0] line_base;
  logic [X_W-1:0]    src_x;
  logic [SUB_W-1:0]  sub_x;
  logic [SUB_W-1:0]  sub_y;

  // Source coordinates tracked incrementally so no multiplier is needed.
  always_ff @(posedge display_out_clk) begin
    if (rst) begin
      line_base  <= '0;
      src_x      <= '0;
      sub_x      <= '0;
      sub_y      <= '0;
      fb_rd_addr <= '0;
    end else begin
      fb_rd_addr <= active_c ? line_base + ADDR_W'(src_x) : '0;
      if (h_wrap_c) begin
        src_x <= '0;
        sub_x <= '0;
        if (v_wrap_c) begin
          line_base <= '0;
          sub_y     <= '0;
        end else if (v_active_c) begin
          if (sub_y == SUB_W'(SCALE - 1)) begin
            sub_y     <= '0;
            line_base <= line_base + ADDR_W'(DISPLAY_WIDTH);
          end else begin
            sub_y <= sub_y + SUB_W'(1);
          end
        end
      end else if (active_c) begin
        if (sub_x == SUB_W'(SCALE - 1)) begin
          sub_x <= '0;
          src_x <= src_x + X_W'(1);
        end else begin
          sub_x <= sub_x + SUB_W'(1);
        end
      end
    end
  end

  // Bit 0 is the newest stage; bit PIPE-1 lines up with fb_rd_data.
  logic [PIPE-1:0] de_sr, hs_sr, vs_sr, fs_sr;

  always_ff @(posedge display_out_clk) begin
    if (rst) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
      fs_sr <= '0;
    end else begin
      de_sr <= PIPE'({de_sr, active_c});
      hs_sr <= PIPE'({hs_sr, hsync_c});
      vs_sr <= PIPE'({vs_sr, vsync_c});
      fs_sr <= PIPE'({fs_sr, frame_start_c});
    end
  end

  pixel_t pixel_q;

  always_ff @(posedge display_out_clk) begin
    if (rst) begin
      pixel_q     <= '0;
      de          <= 1'b0;
      hsync       <= !SYNC_ACTIVE;
      vsync       <= !SYNC_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      pixel_q     <= de_sr[PIPE-1] ? pixel_t'(fb_rd_data) : '0;
      de          <= de_sr[PIPE-1];
      hsync       <= hs_sr[PIPE-1] ? SYNC_ACTIVE : !SYNC_ACTIVE;
      vsync       <= vs_sr[PIPE-1] ? SYNC_ACTIVE : !SYNC_ACTIVE;
      frame_start <= fs_sr[PIPE-1];
    end
  end

  assign pixel_out = pixel_q;

endmodule
